// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter
//   Packet-atomic arbiter that shares the single ULPI transmit AXI4-Stream
//   between several packet encoders (handshake responder, control data, bulk
//   data). Source 0 has fixed top priority. The other sources are served
//   round-robin. A grant is held until the beat carrying tlast has
//   transferred. After that, HOLDOFF idle cycles are forced before the next
//   grant. No new packet starts while usb_busy_i is high.
//
// Ports
//   clock, reset         usb_clock domain clock; asynchronous active-high reset
//   usb_busy_i           PHY owns the bus / receive in progress (blocks new grants)
//   s_t*_i / s_tready_o  per-source AXI4-Stream inputs; source k data at [k*WIDTH +: WIDTH]
//   m_t*_o / m_tready_i  merged AXI4-Stream output toward the ULPI interface
//   grant_o              one-hot current owner (0 when no owner)
//   active_o             high while a packet is being forwarded
//   error_o              one-cycle pulse on a mid-packet stall timeout
//
// Build option
//   USB_TX_ARB_TIMEOUT_EN : adds a stall counter. If the owner stays idle for
//                           TIMEOUT cycles in mid-packet, the grant is dropped
//                           and error_o pulses. Without it, error_o is tied 0
//                           and a stall may last indefinitely.

module usb_tx_arbiter #(
  parameter int SOURCES = 3,
  parameter int WIDTH   = 8,
  parameter int HOLDOFF = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     usb_busy_i,
  input  logic [SOURCES-1:0]       s_tvalid_i,
  output logic [SOURCES-1:0]       s_tready_o,
  input  logic [SOURCES-1:0]       s_tlast_i,
  input  logic [SOURCES-1:0]       s_tkeep_i,
  input  logic [SOURCES*WIDTH-1:0] s_tdata_i,
  output logic                     m_tvalid_o,
  input  logic                     m_tready_i,
  output logic                     m_tlast_o,
  output logic                     m_tkeep_o,
  output logic [WIDTH-1:0]         m_tdata_o,
  output logic [SOURCES-1:0]       grant_o,
  output logic                     active_o,
  output logic                     error_o
);

  localparam int PW = $clog2(SOURCES);
  localparam int GW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  if (SOURCES < 2 || SOURCES > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("usb_tx_arbiter: SOURCES must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   gidx, gidx_nxt;   // index of current owner, valid in XFER
  logic [PW-1:0]   ptr, ptr_nxt;     // round-robin start point, always 1..SOURCES-1
  logic [GW-1:0]   gap_cnt, gap_nxt;

  logic [SOURCES-1:0][WIDTH-1:0] data_arr;
  assign data_arr = s_tdata_i;

  logic xfer, g_vld, pkt_end, tmo;
  logic sel_any;
  logic [PW-1:0] sel_idx, ptr_inc;

  assign xfer    = (state == XFER);
  assign g_vld   = s_tvalid_i[gidx];
  assign pkt_end = xfer && g_vld && m_tready_i && s_tlast_i[gidx];
  assign ptr_inc = (gidx == PW'(SOURCES-1)) ? PW'(1) : gidx + PW'(1);

  // Source 0 wins outright. Otherwise, scan 1..SOURCES-1 starting at ptr and
  // wrapping back to 1.
  always_comb begin : sel_p
    int idx;
    sel_any = 1'b0;
    sel_idx = '0;
    idx     = 0;
    if (s_tvalid_i[0]) begin
      sel_any = 1'b1;
    end else begin
      for (int i = 0; i < SOURCES-1; i++) begin
        idx = int'(ptr) + i;
        if (idx > SOURCES-1) idx = idx - (SOURCES-1);
        if (!sel_any && s_tvalid_i[idx]) begin
          sel_any = 1'b1;
          sel_idx = PW'(idx);
        end
      end
    end
  end

`ifdef USB_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] stall_cnt;

  // Counts consecutive mid-packet cycles with the owner's tvalid low.
  // The TIMEOUT-th such cycle ends the packet without a tlast.
  assign tmo     = xfer && !g_vld && (stall_cnt == TW'(TIMEOUT-1));
  assign error_o = tmo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   stall_cnt <= '0;
    else if (xfer && !g_vld && !tmo) stall_cnt <= stall_cnt + TW'(1);
    else                         stall_cnt <= '0;
  end
`else
  assign tmo     = 1'b0;
  assign error_o = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gidx    <= '0;
      ptr     <= PW'(1);
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gidx    <= gidx_nxt;
      ptr     <= ptr_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gidx_nxt  = gidx;
    ptr_nxt   = ptr;
    gap_nxt   = gap_cnt;
    case (state)
      IDLE: begin
        if (!usb_busy_i && sel_any) begin
          state_nxt = XFER;
          gidx_nxt  = sel_idx;
        end
      end
      XFER: begin
        // Only the end of the packet (or a stall timeout) releases the bus.
        // Busy and higher-priority requests are ignored until then.
        if (pkt_end || tmo) begin
          if (gidx != '0) ptr_nxt = ptr_inc;
          gap_nxt   = '0;
          state_nxt = (HOLDOFF > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(HOLDOFF-1)) begin
          gap_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt + GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-source grant/ready decode. Ready reaches only the owner.
  for (genvar k = 0; k < SOURCES; k++) begin : g_src
    assign grant_o[k]    = xfer && (gidx == PW'(k));
    assign s_tready_o[k] = grant_o[k] && m_tready_i;
  end

  // Output is a pure combinational mux of the owner, so no latency is added.
  assign active_o   = xfer;
  assign m_tvalid_o = xfer && g_vld;
  assign m_tlast_o  = xfer && s_tlast_i[gidx];
  assign m_tkeep_o  = xfer && s_tkeep_i[gidx];
  assign m_tdata_o  = xfer ? data_arr[gidx] : '0;

endmodule
